// File: rtl/riscv_lsu_pkg.sv
// Shared LSU definitions: access-size encodings (shared with the decoder) and FSM state type.
package riscv_lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp,
    StDone
  } lsu_state_e;

  // Sizes 3, 6 and 7 have no meaning.
  function automatic logic size_invalid(input logic [2:0] size);
    return (size[1:0] == 2'b11) || (size == 3'd6);
  endfunction

endpackage

// File: rtl/riscv_lsu_load_align.sv
// Extracts the addressed byte/half/word from a load word and sign- or zero-extends it.
module riscv_lsu_load_align
  import riscv_lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  size,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    case (size)
      LDST_B:  data = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data = {24'h000000, byte_sel};
      LDST_H:  data = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data = {16'h0000, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: drives the data-memory req/gnt/rvalid handshake, stalls the core while an
// access is in flight and returns aligned, extended load data.
module riscv_lsu
  import riscv_lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              arstn_i,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_size_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic [DATA_W-1:0] lsu_data_o,
  output logic              lsu_stall_req_o,
  output logic              lsu_misaligned_o,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [3:0]        data_be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_gnt_i,
  input  logic              data_rvalid_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  lsu_state_e        state_q;
  logic [2:0]        size_q;
  logic [1:0]        off_q;
  logic              we_q;
  logic [DATA_W-1:0] data_q;

  logic              reject;
  logic              active;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] load_data;

  always_comb begin
    reject = size_invalid(lsu_size_i);
    case (lsu_size_i[1:0])
      2'b01:   reject = reject | lsu_addr_i[0];
      2'b10:   reject = reject | (lsu_addr_i[1:0] != 2'b00);
      default: ;
    endcase
  end

  assign active = lsu_req_i & ~reject;

  // Unsigned variants share the byte/half lane logic; stores treat BU/HU as B/H.
  always_comb begin
    be    = 4'b0000;
    wdata = '0;
    case (lsu_size_i[1:0])
      2'b00: begin
        be    = 4'b0001 << lsu_addr_i[1:0];
        wdata = {4{lsu_data_i[7:0]}};
      end
      2'b01: begin
        be    = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata = {2{lsu_data_i[15:0]}};
      end
      2'b10: begin
        be    = 4'b1111;
        wdata = lsu_data_i;
      end
      default: ;
    endcase
  end

  assign lsu_misaligned_o = lsu_req_i & reject;
  assign lsu_stall_req_o  = active & (state_q != StDone);
  assign data_req_o       = (state_q == StIdle && active) || (state_q == StReq);
  assign data_we_o        = active & lsu_we_i;
  assign data_be_o        = active ? be : 4'b0000;
  assign data_addr_o      = active ? {lsu_addr_i[ADDR_W-1:2], 2'b00} : '0;
  assign data_wdata_o     = active ? wdata : '0;
  assign lsu_data_o       = data_q;

  riscv_lsu_load_align u_load_align (
    .rdata  (data_rdata_i),
    .offset (off_q),
    .size   (size_q),
    .data   (load_data)
  );

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= StIdle;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      data_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (active) begin
            size_q  <= lsu_size_i;
            off_q   <= lsu_addr_i[1:0];
            we_q    <= lsu_we_i;
            state_q <= data_gnt_i ? StResp : StReq;
          end
        end
        StReq: begin
          if (data_gnt_i) state_q <= StResp;
        end
        // An rvalid coincident with gnt was seen in IDLE/REQ and is therefore ignored.
        StResp: begin
          if (data_rvalid_i) begin
            if (!we_q) data_q <= load_data;
            state_q <= StDone;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit directly downstream of the decoder. Consumes mem_req/mem_we/mem_size from decode, the ALU-computed address and rs2 data. Drives the data-memory request/grant/rvalid interface. Returns aligned, sign/zero-extended load data and a stall request that freezes the core's PC and pipeline until the access completes.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
- clk_i  in  1  core clock
- arstn_i  in  1  reset; asynchronous, active-low
- lsu_req_i  in  1  memory access request (decoder mem_req_o)
- lsu_we_i  in  1  1=store, 0=load (decoder mem_we_o)
- lsu_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5
- lsu_addr_i  in  32  byte address (ALU result)
- lsu_data_i  in  32  store data (rs2)
- lsu_data_o  out  32  extended load data, registered
- lsu_stall_req_o  out  1  hold core while access in progress
- lsu_misaligned_o  out  1  access rejected (misaligned or bad size)
- data_req_o  out  1  memory request
- data_we_o  out  1  memory write enable
- data_be_o  out  4  byte enables
- data_addr_o  out  32  word address {addr[31:2],2'b00}
- data_wdata_o  out  32  lane-replicated store data
- data_gnt_i  in  1  memory accepted request
- data_rvalid_i  in  1  response valid (load data or store ack)
- data_rdata_i  in  32  load word

Behaviour:
- Reset (async, arstn_i=0): state=IDLE; lsu_data_o=0; captured size/offset=0. Combinational outputs then evaluate to 0 unless lsu_req_i is set in IDLE.
- Core contract: lsu_req_i and all lsu_* inputs stay stable while lsu_stall_req_o=1.
- Reject check (combinational): size in {3,6,7}; H/HU with addr[0]=1; W with addr[1:0]!=0.
  - On reject: lsu_misaligned_o=1, no data_req_o, stall=0, and the FSM stays in IDLE.
  - Stores with BU/HU behave as B/H.
- FSM states IDLE, REQ, RESP, DONE:
  - IDLE: if lsu_req_i and accepted, data_req_o=1. Capture size and addr[1:0]. Go to RESP on data_gnt_i, else go to REQ.
  - REQ: data_req_o=1 with stable addr/we/be/wdata until data_gnt_i, then go to RESP.
  - RESP: data_req_o=0. Wait for data_rvalid_i. On rvalid, a load registers extracted data into lsu_data_o; a store leaves lsu_data_o unchanged. Go to DONE.
  - DONE: stall=0 for exactly one cycle so the core retires the instruction. Unconditionally go to IDLE.
- lsu_stall_req_o = lsu_req_i & accepted & (state != DONE). It is asserted combinationally from the first request cycle.
- Minimum latency (gnt in cycle 0, rvalid in cycle 1): stall high in cycles 0–1, data valid and stall low in cycle 2.
- data_rvalid_i in IDLE or REQ is ignored. An rvalid arriving in the same cycle as gnt is not used; the FSM waits for the next rvalid.
- Byte enables and store data:
  - B: be=0001<<addr[1:0], wdata={4{d[7:0]}}
  - H: be=addr[1]?1100:0011, wdata={2{d[15:0]}}
  - W: be=1111, wdata=d
  - Loads drive be per size too; data_we_o=lsu_we_i.
- Load extraction uses the captured offset:
  - B/BU selects byte rdata[8*off+:8], sign- or zero-extended.
  - H/HU selects rdata[16*off[1]+:16], extended.
  - W passes rdata through.
- Reset mid-access: return to IDLE immediately. A late gnt/rvalid from the memory is ignored. The memory model is reset in the same domain.

Decomposition:
- Shared package/header: LDST_* size encodings (already used by the decoder) and the LSU state encoding.
- Natural sub-module: riscv_lsu_load_align. Pure combinational: rdata, offset, size → extended 32-bit value. It is reusable and testable in isolation.
- FSM, byte-enable and wdata replication stay in riscv_lsu.

Test Plan:
- LW addr=0x100, gnt same cycle, rvalid next with rdata=0xDEADBEEF → data_addr_o=0x100, be=1111, stall high 2 cycles, lsu_data_o=0xDEADBEEF in cycle 2.
- LB addr=0x103 with rdata=0x80112233 → lsu_data_o=0xFFFFFF80; LBU same → 0x00000080; LHU addr=0x102 → 0x00008011.
- SB addr=0x201, data=0x000000A5, gnt delayed 3 cycles → be=0010, wdata=0xA5A5A5A5, addr/be stable through REQ, stall held until DONE, lsu_data_o unchanged.
- LW addr=0x102, then LH addr=0x101, then size=3 → misaligned_o=1, data_req_o=0, stall=0 each case.
- Drive arstn_i low in RESP, then pulse rvalid after release → FSM in IDLE, lsu_data_o=0, no stall, rvalid ignored.
- Back-to-back SW then LW, both with 0-cycle gnt → second access starts the cycle after DONE with no lost or duplicated data_req_o.
